// File: rtl/vacc_readout.sv
// vacc_readout: sweeps one completed accumulator buffer out of a pipelined BRAM port
// and streams it over valid/ready, using a credit-limited FWFT FIFO to absorb the read pipeline.
module vacc_readout #(
    parameter int ACC_WIDTH       = 12,
    parameter int VECTOR_LENGTH   = 32,
    parameter int VECTOR_LEN_BITS = $clog2(VECTOR_LENGTH),
    parameter int RAM_LATENCY     = 2,
    parameter int FIFO_DEPTH      = RAM_LATENCY + 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       dump_req,
    input  logic                       dump_buf,
    output logic                       busy,
    output logic                       overrun,
    output logic                       ram_en,
    output logic [VECTOR_LEN_BITS:0]   ram_addr,
    input  logic [ACC_WIDTH-1:0]       ram_din,
    output logic [ACC_WIDTH-1:0]       dout,
    output logic [VECTOR_LEN_BITS-1:0] dout_index,
    output logic                       dout_last,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic [1:0]                 dbg_state
);

    // Output handshake: a word transfers in any cycle where dout_valid & dout_ready;
    // once raised, dout_valid and the payload stay fixed until that transfer happens.

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [VECTOR_LEN_BITS-1:0] LAST_IDX = VECTOR_LEN_BITS'(VECTOR_LENGTH - 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic                       buf_q, buf_d;
    logic [VECTOR_LEN_BITS-1:0] idx_q, idx_d;
    logic                       overrun_q, overrun_d;
    logic [VECTOR_LEN_BITS:0]   addr_q;

    logic [RAM_LATENCY-1:0]     trk_vld_q;
    logic [VECTOR_LEN_BITS-1:0] trk_idx_q [RAM_LATENCY];

    logic [ACC_WIDTH-1:0]       fifo_data_q [FIFO_DEPTH];
    logic [VECTOR_LEN_BITS-1:0] fifo_idx_q  [FIFO_DEPTH];
    logic [PW-1:0]              wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]              fifo_cnt_q;

    logic [CW-1:0]              inflight;
    logic [CW:0]                occ_sum;
    logic                       issue, fifo_wr, fifo_rd, last_hs;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RAM_LATENCY; i++) begin
            inflight = inflight + CW'(trk_vld_q[i]);
        end
    end

    // Credit counts words already buffered plus reads still travelling through the BRAM.
    assign occ_sum    = {1'b0, fifo_cnt_q} + {1'b0, inflight};
    assign issue      = (state_q == S_READ) && (occ_sum < DEPTH_W);
    assign fifo_wr    = trk_vld_q[RAM_LATENCY-1];
    assign dout_valid = (fifo_cnt_q != '0);
    assign fifo_rd    = dout_valid && dout_ready;
    assign dout       = dout_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign dout_index = dout_valid ? fifo_idx_q[rd_ptr_q] : '0;
    assign dout_last  = dout_valid && (fifo_idx_q[rd_ptr_q] == LAST_IDX);
    assign last_hs    = fifo_rd && dout_last;

    assign ram_en    = issue;
    assign ram_addr  = issue ? {buf_q, idx_q} : addr_q;
    assign busy      = (state_q != S_IDLE);
    assign overrun   = overrun_q;
    assign dbg_state = state_q;

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        idx_d     = idx_q;
        overrun_d = overrun_q;
        if (dump_req && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (dump_req) begin
                    buf_d   = dump_buf;
                    idx_d   = '0;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (issue) begin
                    idx_d = idx_q + VECTOR_LEN_BITS'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (last_hs) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            buf_q      <= 1'b0;
            idx_q      <= '0;
            overrun_q  <= 1'b0;
            addr_q     <= '0;
            trk_vld_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
            addr_q    <= ram_addr;
            trk_vld_q[0] <= issue;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                trk_vld_q[i] <= trk_vld_q[i-1];
            end
            if (fifo_wr) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (fifo_rd) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({fifo_wr, fifo_rd})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + CW'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - CW'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    // Payload storage needs no reset: occupancy and valid bits gate everything it feeds.
    always_ff @(posedge clk) begin
        trk_idx_q[0] <= idx_q;
        for (int i = 1; i < RAM_LATENCY; i++) begin
            trk_idx_q[i] <= trk_idx_q[i-1];
        end
        if (fifo_wr) begin
            fifo_data_q[wr_ptr_q] <= ram_din;
            fifo_idx_q[wr_ptr_q]  <= trk_idx_q[RAM_LATENCY-1];
        end
    end

endmodule

// File: tb/tb_vacc_readout.sv
// tb_vacc_readout: directed bench for vacc_readout with BRAM models for latency 2 and 1,
// a scoreboard of expected addresses/words, and cycle-exact latency checks.
module tb_vacc_readout;
  localparam int AW  = 12;
  localparam int VL  = 32;
  localparam int VLB = 5;
  localparam int FD  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT, latency 2 ----------------
  logic           dump_req = 1'b0, dump_buf = 1'b0, dout_ready = 1'b1;
  logic           busy, overrun, ram_en, dout_last, dout_valid;
  logic [VLB:0]   ram_addr;
  logic [AW-1:0]  ram_din, dout;
  logic [VLB-1:0] dout_index;
  logic [1:0]     dbg_state;

  vacc_readout #(.ACC_WIDTH(AW), .VECTOR_LENGTH(VL), .RAM_LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n), .dump_req(dump_req), .dump_buf(dump_buf),
    .busy(busy), .overrun(overrun), .ram_en(ram_en), .ram_addr(ram_addr),
    .ram_din(ram_din), .dout(dout), .dout_index(dout_index), .dout_last(dout_last),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dbg_state(dbg_state)
  );

  logic [AW-1:0] ram_s1 = '0, ram_s2 = '0;
  always @(posedge clk) begin
    if (ram_en) ram_s1 <= AW'(ram_addr) + 12'h100;
    ram_s2 <= ram_s1;
  end
  assign ram_din = ram_s2;

  // ---------------- DUT, latency 1 ----------------
  logic           dump_req1 = 1'b0, dump_buf1 = 1'b0, dout_ready1 = 1'b1;
  logic           busy1, overrun1, ram_en1, dout_last1, dout_valid1;
  logic [VLB:0]   ram_addr1;
  logic [AW-1:0]  ram_din1, dout1;
  logic [VLB-1:0] dout_index1;
  logic [1:0]     dbg_state1;

  vacc_readout #(.ACC_WIDTH(AW), .VECTOR_LENGTH(VL), .RAM_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .dump_req(dump_req1), .dump_buf(dump_buf1),
    .busy(busy1), .overrun(overrun1), .ram_en(ram_en1), .ram_addr(ram_addr1),
    .ram_din(ram_din1), .dout(dout1), .dout_index(dout_index1), .dout_last(dout_last1),
    .dout_valid(dout_valid1), .dout_ready(dout_ready1), .dbg_state(dbg_state1)
  );

  logic [AW-1:0] ram1_s1 = '0;
  always @(posedge clk) if (ram_en1) ram1_s1 <= AW'(ram_addr1) + 12'h100;
  assign ram_din1 = ram1_s1;

  // ---------------- checking ----------------
  int n_checks = 0, n_fail = 0;
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [1+VLB+AW-1:0] exp_q[$];
  logic [VLB:0]        exp_addr_q[$];
  int t0 = 0;
  int hs_cnt, en_cnt, first_en, last_en, first_vld, last_hs, busy_fall, max_occ, wr_full;
  logic                hold = 1'b0;
  logic [1+VLB+AW:0]   hold_val;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      hold = 1'b0;
      continue;
    end
    if (hold) check_eq("stall_stable", 32'({dout_valid, dout_last, dout_index, dout}), 32'(hold_val));
    if (ram_en) begin
      en_cnt++;
      if (first_en < 0) first_en = cyc;
      last_en = cyc;
      check_eq("ram_addr", 32'(ram_addr),
               exp_addr_q.size() > 0 ? 32'(exp_addr_q.pop_front()) : 32'hDEAD);
    end
    if (int'(dut.fifo_cnt_q) > max_occ) max_occ = int'(dut.fifo_cnt_q);
    if (dut.fifo_wr && int'(dut.fifo_cnt_q) == FD) wr_full++;
    if (dout_valid && first_vld < 0) first_vld = cyc;
    if (dout_valid && dout_ready) begin
      hs_cnt++;
      if (dout_last) last_hs = cyc;
      check_eq("dout_word", 32'({dout_last, dout_index, dout}),
               exp_q.size() > 0 ? 32'(exp_q.pop_front()) : 32'hDEAD_BEEF);
    end
    if (busy_fall < 0 && first_en >= 0 && !busy) busy_fall = cyc;
    hold     = dout_valid && !dout_ready;
    hold_val = {dout_valid, dout_last, dout_index, dout};
  end

  // ---------------- ready driver ----------------
  int          rdy_mode = 0;
  logic [15:0] lfsr = 16'hACE1;
  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      1: begin
        lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        dout_ready = lfsr[0];
      end
      2: dout_ready = (cyc > t0 + 50);
      default: dout_ready = 1'b1;
    endcase
  end

  // ---------------- driver tasks ----------------
  task automatic goto_cycle(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic start_sweep(input logic b);
    @(posedge clk); #1;
    t0 = cyc;
    hs_cnt = 0; en_cnt = 0; first_en = -1; last_en = -1; first_vld = -1;
    last_hs = -1; busy_fall = -1; max_occ = 0; wr_full = 0;
    for (int i = 0; i < VL; i++) begin
      exp_addr_q.push_back({b, VLB'(i)});
      exp_q.push_back({(i == VL - 1), VLB'(i), AW'({b, VLB'(i)}) + 12'h100});
    end
    dump_req = 1'b1; dump_buf = b;
    @(posedge clk); #1;
    dump_req = 1'b0;
  endtask

  task automatic pulse_req(input logic b);
    dump_req = 1'b1; dump_buf = b;
    @(posedge clk); #1;
    dump_req = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) break;
    end
    check_eq({tag, "_words_left"}, 32'(exp_q.size()), 32'd0);
    check_eq({tag, "_busy_end"}, 32'(busy), 32'd0);
    check_eq({tag, "_handshakes"}, 32'(hs_cnt), 32'(VL));
    check_eq({tag, "_fifo_write_full"}, 32'(wr_full), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  int t1, first1, last1, hs1;
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_overrun", 32'(overrun), 32'd0);
    check_eq("rst_ram_en", 32'(ram_en), 32'd0);
    check_eq("rst_ram_addr", 32'(ram_addr), 32'd0);
    check_eq("rst_dout", 32'({dout_last, dout_index, dout}), 32'd0);
    check_eq("rst_dout_valid", 32'(dout_valid), 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;

    // Test 1: buffer 1, ready always high, exact timing
    rdy_mode = 0;
    start_sweep(1'b1);
    wait_idle("t1", 200);
    check_eq("t1_read_count", 32'(en_cnt), 32'd32);
    check_eq("t1_first_ram_en", 32'(first_en - t0), 32'd1);
    check_eq("t1_last_ram_en", 32'(last_en - t0), 32'd32);
    check_eq("t1_first_valid", 32'(first_vld - t0), 32'd4);
    check_eq("t1_last_hs", 32'(last_hs - t0), 32'd35);
    check_eq("t1_busy_fall", 32'(busy_fall - t0), 32'd36);
    check_eq("t1_ram_addr_held", 32'(ram_addr), 32'h3F);

    // Test 2: pseudo-random backpressure
    rdy_mode = 1;
    start_sweep(1'b0);
    wait_idle("t2", 600);
    check_eq("t2_occ_within_depth", 32'(max_occ <= FD), 32'd1);
    rdy_mode = 0;

    // Test 3: ready held low for 50 cycles
    t0 = cyc + 1;
    rdy_mode = 2;
    start_sweep(1'b1);
    goto_cycle(t0 + 50);
    @(negedge clk);
    check_eq("t3_reads_during_stall", 32'(en_cnt), 32'd4);
    check_eq("t3_occ_during_stall", 32'(max_occ), 32'(FD));
    check_eq("t3_valid_during_stall", 32'(dout_valid), 32'd1);
    wait_idle("t3", 300);
    check_eq("t3_total_reads", 32'(en_cnt), 32'd32);
    rdy_mode = 0;

    // Test 4: dump_req while busy sets sticky overrun, sweep unaffected
    start_sweep(1'b0);
    goto_cycle(t0 + 10);
    pulse_req(1'b1);
    check_eq("t4_overrun_mid", 32'(overrun), 32'd1);
    goto_cycle(t0 + 35);
    pulse_req(1'b1);
    wait_idle("t4", 200);
    check_eq("t4_last_hs", 32'(last_hs - t0), 32'd35);
    repeat (5) @(negedge clk);
    check_eq("t4_overrun_sticky", 32'(overrun), 32'd1);
    start_sweep(1'b1);
    wait_idle("t4b", 200);
    check_eq("t4b_first_valid", 32'(first_vld - t0), 32'd4);
    check_eq("t4b_overrun_still", 32'(overrun), 32'd1);

    // Test 5: reset mid-sweep at word 17
    start_sweep(1'b1);
    for (int i = 0; i < 100 && hs_cnt < 17; i++) begin
      @(posedge clk); #1;
    end
    check_eq("t5_reached_word17", 32'(hs_cnt), 32'd17);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_eq("t5_rst_valid", 32'(dout_valid), 32'd0);
    check_eq("t5_rst_busy", 32'(busy), 32'd0);
    check_eq("t5_rst_ram_en", 32'(ram_en), 32'd0);
    check_eq("t5_rst_overrun", 32'(overrun), 32'd0);
    exp_q.delete();
    exp_addr_q.delete();
    repeat (4) @(posedge clk);
    #1;
    check_eq("t5_no_valid_after_rst", 32'(dout_valid), 32'd0);
    start_sweep(1'b0);
    wait_idle("t5", 200);
    check_eq("t5_first_valid", 32'(first_vld - t0), 32'd4);

    // Test 6: latency-1 build, ready always high
    @(posedge clk); #1;
    t1 = cyc;
    dump_req1 = 1'b1;
    @(posedge clk); #1;
    dump_req1 = 1'b0;
    first1 = -1; last1 = -1; hs1 = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (dout_valid1 && first1 < 0) first1 = cyc;
      if (dout_valid1 && dout_ready1) begin
        check_eq("l1_dout_word", 32'({dout_last1, dout_index1, dout1}),
                 32'({(hs1 == VL - 1), VLB'(hs1), AW'(hs1) + 12'h100}));
        if (dout_last1) last1 = cyc;
        hs1++;
      end
    end
    check_eq("l1_handshakes", 32'(hs1), 32'd32);
    check_eq("l1_first_valid", 32'(first1 - t1), 32'd3);
    check_eq("l1_last_hs", 32'(last1 - t1), 32'd34);
    check_eq("l1_busy_end", 32'(busy1), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
